// File: rtl/ring_node_if.sv
// ring_node_if: PU and ring packet ports of one ring stop
interface ring_node_if #(
  parameter int PKT_W = 32,
  parameter int FIFO_DEPTH = 4
);
  logic [PKT_W-1:0] pu_tx;
  logic [PKT_W-1:0] pu_rx;
  logic [PKT_W-1:0] ring_in;
  logic [PKT_W-1:0] ring_out;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic overflow;
  modport master (output pu_tx, ring_in, input pu_rx, ring_out, fifo_count, overflow);
  modport slave (input pu_tx, ring_in, output pu_rx, ring_out, fifo_count, overflow);
endinterface

// File: rtl/ring_node.sv
// ring_node: ring stop that ejects local packets, forwards the rest and injects PU packets into free slots
module ring_node #(
  parameter logic [1:0] NODE_ID = 2'd0,
  parameter int PKT_W = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  ring_node_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic [PKT_W-1:0] rx_q, out_q;
  logic ovf_q;
  logic in_v, eject, fwd, pop, tx_v, full, push;
  assign in_v = bus.ring_in[PKT_W-1];
  assign eject = in_v && bus.ring_in[PKT_W-2 -: 2] == NODE_ID;
  assign fwd = in_v && !eject;
  assign pop = !fwd && cnt != '0;
  assign tx_v = bus.pu_tx[PKT_W-1];
  assign full = cnt == CW'(FIFO_DEPTH);
  assign push = tx_v && (!full || pop);
  assign bus.pu_rx = rx_q;
  assign bus.ring_out = out_q;
  assign bus.fifo_count = cnt;
  assign bus.overflow = ovf_q;
  // FIFO storage; stale entries are unreachable once the pointers reset
  always_ff @(posedge clk)
    if (push) mem[wr] <= bus.pu_tx;
  // pointers, occupancy, sticky drop flag and registered ring/PU outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      ovf_q <= 1'b0;
      rx_q <= '0;
      out_q <= '0;
    end else begin
      rd <= pop ? rd + AW'(1) : rd;
      wr <= push ? wr + AW'(1) : wr;
      cnt <= cnt + CW'(push) - CW'(pop);
      ovf_q <= ovf_q || (tx_v && !push);
      rx_q <= eject ? bus.ring_in : '0;
      out_q <= fwd ? bus.ring_in : pop ? mem[rd] : '0;
    end
  end
endmodule

// File: doc/ring_node.md
Name: ring_node

Overview:
- Network stop between one processing unit and the unidirectional inter-PU packet ring. One instance per PU.
- Consumes the packet the PU emits on its tx port and buffers it in an injection FIFO.
- Injects the buffered packet onto the ring when a slot is free.
- Ejects ring packets addressed to this node and drives them into the PU's rx port. All other ring traffic is forwarded.

Parameters:
- NODE_ID, 2'd0, ring address of this node; same value as the attached PU's pu_num.
- PKT_W, 32, total packet width in bits (bit PKT_W-1 = valid, bits PKT_W-2:PKT_W-3 = destination node, remainder = payload).
- FIFO_DEPTH, 4, injection FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- pu_tx  input  PKT_W  packet from the PU; valid bit set for exactly one cycle per packet; there is no backpressure.
- pu_rx  output  PKT_W  packet to the PU; all-zero when idle.
- ring_in  input  PKT_W  packet arriving from the upstream ring node.
- ring_out  output  PKT_W  packet to the downstream ring node; all-zero when idle.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current injection FIFO occupancy.
- overflow  output  1  sticky flag: a pu_tx packet was dropped.

Behaviour:
- Reset: rst low at a clk edge clears the following:
  - pu_rx, ring_out, fifo_count and overflow go to 0.
  - FIFO read and write pointers go to 0, and FIFO contents are discarded.
  - Packets in flight are lost; nothing is emitted in the cycle after reset.
- Valid test: a packet is valid iff bit PKT_W-1 = 1. Invalid inputs are ignored regardless of their other bits.
- Eject: if ring_in is valid and its dest = NODE_ID:
  - pu_rx <= ring_in at the next edge (1-cycle latency);
  - the ring slot becomes free this cycle.
- Forward: if ring_in is valid and its dest != NODE_ID:
  - ring_out <= ring_in at the next edge (1-cycle latency);
  - the slot is occupied; no injection this cycle.
- Inject: if the slot is free (ring_in invalid or ejected) and the FIFO is non-empty:
  - ring_out <= FIFO head at the next edge, and the FIFO pops.
- Otherwise ring_out <= 0.
- Ring priority: ring traffic always has priority over injection. The FIFO never stalls the ring.
- Enqueue: pu_tx valid is written to the FIFO tail at the edge ending that cycle.
  - Minimum pu_tx-to-ring_out latency with an idle ring is 2 cycles: write at edge E, pop-select in the cycle after E, ring_out registered at edge E+1 and visible after it.
- FIFO full: pu_tx valid while fifo_count = FIFO_DEPTH and no pop in the same cycle:
  - the packet is dropped and overflow <= 1;
  - overflow stays 1 until reset.
- Full with simultaneous pop: the packet is accepted; the count is unchanged.
- Simultaneous push and pop when non-full: fifo_count is unchanged.
- Pointers: wrap modulo FIFO_DEPTH.
- Self-addressed PU packets (dest = NODE_ID) are injected normally and traverse the full ring. They are ejected when they return, so there is no local loopback path.
- pu_rx is valid for exactly one cycle per ejected packet. Back-to-back ejections produce back-to-back pu_rx pulses.
- Packet bits are carried unmodified through FIFO, ring and eject paths.

Test Plan:
- Reset-mid-operation:
  - Stimulus: NODE_ID=1, FIFO holding 3 packets, ring_in forwarding traffic, then rst=0 for one edge.
  - Required: next cycle pu_rx=0, ring_out=0, fifo_count=0, overflow=0; no stale packet ever appears afterwards.
- Injection latency:
  - Stimulus: NODE_ID=1, ring idle, pu_tx = valid, dest=2, payload 0x1234 for one cycle.
  - Required: fifo_count=1 after edge E; ring_out carries the identical packet after edge E+1; fifo_count=0.
- Eject and forward:
  - Stimulus: ring_in = valid dest=1 payload 0xAA, then valid dest=3 payload 0xBB in consecutive cycles.
  - Required: pu_rx carries the 0xAA packet one cycle later and ring_out carries 0xBB the following cycle.
  - Required: 0xAA never appears on ring_out; 0xBB never appears on pu_rx.
- Ring priority and slot reuse:
  - Stimulus: FIFO holds 1 packet, ring_in forwards for 5 consecutive cycles, then sends one packet with dest=NODE_ID.
  - Required: no injection during the 5 forward cycles.
  - Required: in the eject cycle, the injected packet occupies ring_out and pu_rx gets the ejected packet on the same edge.
- Overflow boundary:
  - Stimulus: ring saturated with forward traffic, 5 pu_tx packets with FIFO_DEPTH=4.
  - Required: fifo_count=4, the 5th packet is dropped, overflow=1 and stays 1.
  - Follow-up: release the ring; the 4 packets exit in order and overflow is still 1.
- Full plus pop:
  - Stimulus: FIFO full, free slot and pu_tx valid in the same cycle.
  - Required: head popped to ring_out, new packet accepted, fifo_count stays 4, overflow stays 0.
